ldl_bin2hot_pipe: RTL
=====================

// Module: ldl_bin2hot_pipe
// PURPOSE
//  Registered binary-to-one-hot / thermometer decoder with valid/ready flow control.
//  Generalises the combinational bin2hot decoder:
//   - output width need not be a power of two; out-of-range codes are flagged
//   - runtime one-hot/thermometer mode select
//   - two-entry skid buffer, so it drops into streaming pipelines at full rate
//     with registered in_rdy
//  Typical use: grant/select vector generation and FIFO-level thermometer displays.
// PARAMETERS
//  BIN_WIDTH  4                width of binary code in_x (>=1)
//  OUT_WIDTH  (1<<BIN_WIDTH)   decoded vector width, 1..(1<<BIN_WIDTH)
// PORTS
//  clk      in   1          clock; all logic rising-edge
//  rst_n    in   1          asynchronous active-low reset
//  in_vld   in   1          input beat valid
//  in_rdy   out  1          block can accept a beat (registered)
//  in_en    in   1          decode enable; 0 -> all-zero vector
//  in_x     in   BIN_WIDTH  binary code
//  in_mode  in   1          0 = one-hot, 1 = thermometer
//  out_vld  out  1          output beat valid
//  out_rdy  in   1          downstream accepts beat
//  out_y    out  OUT_WIDTH  decoded vector
//  out_oor  out  1          in_en=1 and in_x >= OUT_WIDTH (out of range)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_vld=0, out_y=0, out_oor=0, in_rdy=1; state EMPTY; skid contents 0.
//  Transfers:
//   - Input transfer when in_vld&in_rdy; output transfer when out_vld&out_rdy.
//  Decode (combinational on input side, captured on input transfer):
//   - in_en=0: y=0, oor=0.
//   - in_en=1, in_x<OUT_WIDTH, mode 0: y[in_x]=1, all other bits 0.
//   - in_en=1, in_x<OUT_WIDTH, mode 1: y[i]=1 for every i<=in_x (x=0 -> 1'b1 at bit 0).
//   - in_en=1, in_x>=OUT_WIDTH (either mode): y=0, oor=1.
//   - in_x is zero-extended for the compare; no truncation or wrap of in_x.
//  Storage: main register (drives out_*) plus one skid register.
//  State machine:
//   - EMPTY: out_vld=0. On in xfer: load main -> ONE.
//   - ONE: out_vld=1.
//     - in xfer & out xfer: load main, stay ONE.
//     - out xfer only: -> EMPTY.
//     - in xfer only: load skid -> TWO.
//   - TWO: out_vld=1, in_rdy=0.
//     - On out xfer: main<=skid -> ONE.
//  Readiness:
//   - in_rdy is a flop: 1 in EMPTY/ONE, 0 in TWO; updated with the state.
//   - It never depends combinationally on out_rdy.
//  Latency and throughput:
//   - Latency in xfer -> out_vld: 1 cycle.
//   - Sustained throughput 1 beat/cycle while out_rdy=1.
//  Ordering and stability:
//   - Beats leave in arrival order; none dropped or duplicated.
//   - out_y/out_oor hold stable while out_vld=1 and out_rdy=0.
//  Boundary rules:
//   - in_vld while in_rdy=0 is ignored (no capture). Source must hold the beat.
//   - out_rdy toggling with out_vld=0 has no effect.
//   - Reset mid-stream discards all held beats; out_vld falls immediately (async).
//   - OUT_WIDTH=1: x=0 -> y=1 in both modes; any x>0 -> oor.
// TESTING
//  1 Reset: hold rst_n=0 with in_vld=1 -> out_vld=0, out_y=0, in_rdy=1; release -> first beat 1 cycle later.
//  2 Defaults BIN_WIDTH=4, mode 0, out_rdy=1: stream x=0..15 back-to-back ->
//    out_y=16'h0001..16'h8000 on consecutive cycles, in_rdy stays 1.
//  3 Mode 1, en=1: x=0 -> 16'h0001; x=5 -> 16'h003F; x=15 -> 16'hFFFF. en=0, x=7 -> 16'h0000, oor=0.
//  4 OUT_WIDTH=10: x=9 mode 0 -> 10'h200, oor=0; x=10 and x=15 (both modes) -> y=0, oor=1.
//  5 Backpressure: out_rdy=0, send x=1, x=2 ->
//    - in_rdy=0 after the 2nd beat; 3rd beat x=3 held by source.
//    - out_y holds 16'h0002 (from x=1) stable.
//    - out_rdy=1 -> outputs 0x0002, 0x0004, 0x0008 in order, no loss.
//  6 Random in_vld/out_rdy, 10k beats vs reference model: order preserved, stability rule holds.
//    Async reset pulse mid-stream -> out_vld=0 same cycle, no stale beat after release.

Source files
------------

// File: rtl/ldl_bin2hot_pipe.sv
// ldl_bin2hot_pipe
//   Registered binary-to-one-hot / thermometer decoder with valid/ready flow
//   control and a two-entry skid buffer (main + skid register). The buffer
//   keeps full rate with a registered in_rdy.
//
// Parameters
//   BIN_WIDTH  width of the binary code in_x (>= 1, <= 32)
//   OUT_WIDTH  decoded vector width, 1 .. (1 << BIN_WIDTH)
//
// Ports
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset (async assert, sync release)
//   in_vld   input beat valid
//   in_rdy   block can accept a beat (flop)
//   in_en    decode enable; 0 gives an all-zero vector
//   in_x     binary code
//   in_mode  0 = one-hot, 1 = thermometer
//   out_vld  output beat valid
//   out_rdy  downstream accepts the beat
//   out_y    decoded vector
//   out_oor  in_en = 1 and in_x >= OUT_WIDTH
//
// Handshake: a beat moves on a port in every cycle where its valid and ready
// are both high at the rising edge. in_vld may be high while in_rdy is low,
// and the source then holds the beat. The output beat stays stable while
// out_vld is high and out_rdy is low. in_rdy never depends combinationally on
// out_rdy.
//
// The FSM state is the internal signal "state". It can be probed
// hierarchically.
module ldl_bin2hot_pipe #(
  parameter int BIN_WIDTH = 4,
  parameter int OUT_WIDTH = (1 << BIN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 in_en,
  input  logic [BIN_WIDTH-1:0] in_x,
  input  logic                 in_mode,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [OUT_WIDTH-1:0] out_y,
  output logic                 out_oor
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 load_main;
  logic                 load_skid;
  logic                 skid_to_main;
  logic                 rdy_nxt;

  logic [31:0]          x_ext;
  logic [OUT_WIDTH-1:0] dec_y;
  logic                 dec_oor;
  logic [OUT_WIDTH-1:0] main_y;
  logic                 main_oor;
  logic [OUT_WIDTH-1:0] skid_y;
  logic                 skid_oor;

  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = out_vld & out_rdy;

  // Decode. in_x is zero-extended to 32 bits, so a code at or above
  // OUT_WIDTH is flagged and is never wrapped onto a valid bit.
  always_comb begin
    x_ext   = 32'(in_x);
    dec_y   = '0;
    dec_oor = 1'b0;
    if (in_en) begin
      if (x_ext >= 32'(OUT_WIDTH)) begin
        dec_oor = 1'b1;
      end else begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
          dec_y[i] = in_mode ? (32'(i) <= x_ext) : (32'(i) == x_ext);
        end
      end
    end
  end

  // FSM next state and datapath load controls.
  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end
      end
      TWO: begin
        // in_rdy is low here, so only the output side can move.
        if (out_xfer) begin
          skid_to_main = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    rdy_nxt = (state_nxt != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      in_rdy <= 1'b1;
    end else begin
      state  <= state_nxt;
      in_rdy <= rdy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_y   <= '0;
      main_oor <= 1'b0;
      skid_y   <= '0;
      skid_oor <= 1'b0;
    end else begin
      if (load_main) begin
        main_y   <= dec_y;
        main_oor <= dec_oor;
      end else if (skid_to_main) begin
        main_y   <= skid_y;
        main_oor <= skid_oor;
      end
      if (load_skid) begin
        skid_y   <= dec_y;
        skid_oor <= dec_oor;
      end
    end
  end

  // The decode from state means reset clears out_vld asynchronously.
  assign out_vld = (state != EMPTY);
  assign out_y   = main_y;
  assign out_oor = main_oor;

endmodule
